// File: rtl/scarv_soc_bram_if.sv
// Memory-bus to dual-latency BRAM bridge with in-order response FIFO.
// Ports: g_clk/g_resetn; mem_* request/response bus; bram_* BRAM port.
//
//   g_clk, g_resetn        clock, synchronous active-low reset
//   mem_req/mem_gnt        request handshake (accept = req && gnt)
//   mem_wen/strb/addr/wdata request fields
//   mem_recv/mem_ack       response handshake (consume = recv && ack)
//   mem_error/mem_rdata    response payload
//   bram_rst/en/we/addr/wdata/rdata  BRAM port, read latency 2
module scarv_soc_bram_if #(
    parameter int          DEPTH    = 1024,
    parameter logic [31:0] BASE     = 32'h0,
    parameter int          WRITE_EN = 1
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     mem_req,
    output logic                     mem_gnt,
    input  logic                     mem_wen,
    input  logic [3:0]               mem_strb,
    input  logic [31:0]              mem_addr,
    input  logic [31:0]              mem_wdata,
    output logic                     mem_recv,
    input  logic                     mem_ack,
    output logic                     mem_error,
    output logic [31:0]              mem_rdata,
    output logic                     bram_rst,
    output logic                     bram_en,
    output logic [3:0]               bram_we,
    output logic [$clog2(DEPTH)-1:0] bram_addr,
    output logic [31:0]              bram_wdata,
    input  logic [31:0]              bram_rdata
);

    localparam int LW = $clog2(DEPTH);

    typedef struct packed {
        logic valid;
        logic wen;
        logic err;
    } stage_t;

    stage_t      s1;
    stage_t      s2;

    logic [31:0] fifo_rdata [4];
    logic [3:0]  fifo_err;
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  count;

    logic        req_err;
    logic        accept;
    logic        access;
    logic        push;
    logic        pop;
    logic [3:0]  inflight;
    logic [31:0] push_rdata;

    assign req_err = (mem_addr[31:LW] != BASE[31:LW])
                   || (mem_wen && (WRITE_EN == 0));

    // Every request in s1/s2 already owns a FIFO slot, so the FIFO
    // can never overflow. A same-cycle pop is deliberately ignored.
    assign inflight = {1'b0, count}
                    + {3'b000, s1.valid}
                    + {3'b000, s2.valid};

    assign mem_gnt = g_resetn && (inflight < 4'd4);
    assign accept  = mem_req && mem_gnt;
    assign access  = accept && !req_err;

    // s1 keeps the port enabled so the BRAM output register advances.
    assign bram_rst   = !g_resetn;
    assign bram_en    = g_resetn && (access || s1.valid);
    assign bram_we    = (access && mem_wen) ? mem_strb : 4'h0;
    assign bram_addr  = mem_addr[LW-1:0];
    assign bram_wdata = mem_wdata;

    assign push       = s2.valid;
    assign push_rdata = (!s2.err && !s2.wen) ? bram_rdata : 32'h0;

    assign mem_recv  = g_resetn && (count != 3'd0);
    assign mem_error = mem_recv && fifo_err[rd_ptr];
    assign mem_rdata = mem_recv ? fifo_rdata[rd_ptr] : 32'h0;
    assign pop       = mem_recv && mem_ack;

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            s1     <= '0;
            s2     <= '0;
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            s1.valid <= accept;
            s1.wen   <= mem_wen;
            s1.err   <= req_err;
            s2       <= s1;
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count <= count + {2'b00, push} - {2'b00, pop};
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_resetn && push) begin
            fifo_rdata[wr_ptr] <= push_rdata;
            fifo_err[wr_ptr]   <= s2.err;
        end
    end

endmodule

// File: tb/tb_scarv_soc_bram_if.sv
// Bench for scarv_soc_bram_if: RAM and ROM instances, BRAM models,
// queue-based response checking.
module tb_scarv_soc_bram_if;

    typedef struct {
        logic        err;
        logic [31:0] rd;
        int          acc;
        bit          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        req0 = 1'b0;
    logic        req1 = 1'b0;
    logic        wen = 1'b0;
    logic [3:0]  strb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ack0 = 1'b1;
    logic        ack1 = 1'b1;

    logic        gnt0, recv0, err0, brst0, ben0;
    logic [31:0] rdata0, bwdata0, brdata0;
    logic [3:0]  bwe0;
    logic [9:0]  baddr0;
    logic        gnt1, recv1, err1, brst1, ben1;
    logic [31:0] rdata1, bwdata1, brdata1;
    logic [3:0]  bwe1;
    logic [9:0]  baddr1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   rom_we_seen = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   pop_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    scarv_soc_bram_if #(.DEPTH(1024), .BASE(32'h0), .WRITE_EN(1)) u_ram (
        .g_clk(clk), .g_resetn(resetn),
        .mem_req(req0), .mem_gnt(gnt0), .mem_wen(wen), .mem_strb(strb),
        .mem_addr(addr), .mem_wdata(wdata),
        .mem_recv(recv0), .mem_ack(ack0), .mem_error(err0),
        .mem_rdata(rdata0),
        .bram_rst(brst0), .bram_en(ben0), .bram_we(bwe0),
        .bram_addr(baddr0), .bram_wdata(bwdata0), .bram_rdata(brdata0)
    );

    scarv_soc_bram_if #(.DEPTH(1024), .BASE(32'h0), .WRITE_EN(0)) u_rom (
        .g_clk(clk), .g_resetn(resetn),
        .mem_req(req1), .mem_gnt(gnt1), .mem_wen(wen), .mem_strb(strb),
        .mem_addr(addr), .mem_wdata(wdata),
        .mem_recv(recv1), .mem_ack(ack1), .mem_error(err1),
        .mem_rdata(rdata1),
        .bram_rst(brst1), .bram_en(ben1), .bram_we(bwe1),
        .bram_addr(baddr1), .bram_wdata(bwdata1), .bram_rdata(brdata1)
    );

    // RAM model: input latch then output register, both gated by en.
    logic [31:0] mem0 [256];
    logic [31:0] lat0, oq0;
    always @(posedge clk) begin
        if (ben0) begin
            lat0 <= mem0[baddr0[9:2]];
            oq0  <= lat0;
            for (int b = 0; b < 4; b++)
                if (bwe0[b])
                    mem0[baddr0[9:2]][8*b +: 8] <= bwdata0[8*b +: 8];
        end
    end
    assign brdata0 = oq0;

    // ROM model: read-only contents.
    logic [31:0] mem1 [256];
    logic [31:0] lat1, oq1;
    initial for (int i = 0; i < 256; i++) mem1[i] = 32'hC0DE0000 + i;
    always @(posedge clk) begin
        if (ben1) begin
            lat1 <= mem1[baddr1[9:2]];
            oq1  <= lat1;
        end
    end
    assign brdata1 = oq1;
    always @(negedge clk) if (bwe1 != 4'h0) rom_we_seen++;

    always @(negedge clk) begin
        if (resetn && recv0 && ack0) begin
            checks++;
            pop_cyc.push_back(cyc);
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL resp0_unexpected got err=%b rdata=%h want none",
                         err0, rdata0);
            end else begin
                e0 = q0.pop_front();
                if (err0 !== e0.err || rdata0 !== e0.rd
                    || (e0.lat && (cyc - e0.acc) != 3)) begin
                    errors++;
                    $display("FAIL resp0 got err=%b rdata=%h lat=%0d want err=%b rdata=%h lat=3",
                             err0, rdata0, cyc - e0.acc, e0.err, e0.rd);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resetn && recv1 && ack1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL resp1_unexpected got err=%b rdata=%h want none",
                         err1, rdata1);
            end else begin
                e1 = q1.pop_front();
                if (err1 !== e1.err || rdata1 !== e1.rd) begin
                    errors++;
                    $display("FAIL resp1 got err=%b rdata=%h want err=%b rdata=%h",
                             err1, rdata1, e1.err, e1.rd);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic issue(input bit sel, input bit w, input logic [3:0] s,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit xerr, input logic [31:0] xrd,
                         input bit lat, output int acc, output bit en_at);
        int n;
        n = 0;
        acc = -1;
        en_at = 1'b0;
        wen = w; strb = s; addr = a; wdata = d;
        if (sel) req1 = 1'b1; else req0 = 1'b1;
        while (n < 50) begin
            @(negedge clk);
            if (sel ? gnt1 : gnt0) break;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout got no grant want grant addr=%h", a);
        end else begin
            acc = cyc;
            en_at = sel ? ben1 : ben0;
            if (sel) q1.push_back(exp_t'{err: xerr, rd: xrd, acc: cyc, lat: lat});
            else     q0.push_back(exp_t'{err: xerr, rd: xrd, acc: cyc, lat: lat});
        end
        @(posedge clk); #1;
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        int  accs[8];
        bit  en;
        int  n;
        int  bad;

        // Reset state
        @(negedge clk);
        chk("rst_gnt", {31'b0, gnt0}, 32'h0);
        chk("rst_recv", {31'b0, recv0}, 32'h0);
        chk("rst_err", {31'b0, err0}, 32'h0);
        chk("rst_rdata", rdata0, 32'h0);
        chk("rst_en_we", {27'b0, ben0, bwe0}, 32'h0);
        chk("rst_bram_rst", {31'b0, brst0}, 32'h1);
        idle(2);
        resetn = 1'b1;
        @(negedge clk);
        chk("gnt_after_rst", {31'b0, gnt0}, 32'h1);
        idle(1);

        // Preload words 16..23
        for (int i = 0; i < 8; i++)
            issue(0, 1, 4'hF, 32'h40 + 4*i, 32'hA5A50000 | i, 0, 0, 0, acc, en);

        // Write then read with latency check
        issue(0, 1, 4'hF, 32'h8, 32'hDEADBEEF, 0, 0, 0, acc, en);
        issue(0, 0, 4'h0, 32'h8, 32'h0, 0, 32'hDEADBEEF, 1, acc, en);

        // Byte-lane write
        issue(0, 1, 4'hF, 32'h10, 32'h11223344, 0, 0, 0, acc, en);
        issue(0, 1, 4'b0010, 32'h10, 32'h0000AB00, 0, 0, 0, acc, en);
        issue(0, 0, 4'h0, 32'h10, 32'h0, 0, 32'h1122AB44, 0, acc, en);

        // Zero-strobe write leaves the word intact
        issue(0, 1, 4'h0, 32'h40, 32'hFFFFFFFF, 0, 0, 0, acc, en);
        issue(0, 0, 4'h0, 32'h40, 32'h0, 0, 32'hA5A50000, 0, acc, en);

        // Out-of-range reads
        idle(6);
        issue(0, 0, 4'h0, 32'h400, 32'h0, 1, 32'h0, 0, acc, en);
        chk("oor_bram_en", {31'b0, en}, 32'h0);
        idle(6);
        issue(0, 0, 4'h0, 32'h80000000, 32'h0, 1, 32'h0, 0, acc, en);

        // Back-to-back reads
        idle(10);
        pop_cyc.delete();
        for (int i = 0; i < 8; i++) begin
            issue(0, 0, 4'h0, 32'h40 + 4*i, 32'h0, 0,
                  (i == 0) ? 32'hA5A50000 : (32'hA5A50000 | i), 0, acc, en);
            accs[i] = acc;
        end
        bad = 0;
        for (int i = 1; i < 8; i++) if (accs[i] != accs[0] + i) bad++;
        chk("b2b_accept_gaps", bad, 0);
        idle(10);
        bad = (pop_cyc.size() == 8) ? 0 : 1;
        for (int i = 1; i < pop_cyc.size(); i++)
            if (pop_cyc[i] != pop_cyc[0] + i) bad++;
        chk("b2b_resp_gaps", bad, 0);

        // Credit limit with mem_ack low
        ack0 = 1'b0;
        wen = 1'b0; strb = 4'h0; addr = 32'h40; n = 0;
        req0 = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (gnt0) begin
                q0.push_back(exp_t'{err: 1'b0, rd: 32'hA5A50000 | n,
                                    acc: cyc, lat: 1'b0});
                n++;
            end
            @(posedge clk); #1;
            addr = 32'h40 + 4*n;
        end
        chk("credit_accepts", n, 4);
        @(negedge clk);
        chk("credit_gnt_low", {31'b0, gnt0}, 32'h0);
        @(posedge clk); #1;
        ack0 = 1'b1;
        @(posedge clk); #1;
        ack0 = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (gnt0) begin
                q0.push_back(exp_t'{err: 1'b0, rd: 32'hA5A50000 | n,
                                    acc: cyc, lat: 1'b0});
                n++;
            end
            @(posedge clk); #1;
            addr = 32'h40 + 4*n;
        end
        chk("credit_one_more", n, 5);
        req0 = 1'b0;
        ack0 = 1'b1;
        idle(12);

        // ROM instance
        issue(1, 1, 4'hF, 32'h20, 32'hFFFFFFFF, 1, 32'h0, 0, acc, en);
        issue(1, 0, 4'h0, 32'h20, 32'h0, 0, 32'hC0DE0008, 0, acc, en);
        idle(8);
        chk("rom_no_write", rom_we_seen, 0);

        // Reset with responses pending
        ack0 = 1'b0;
        for (int i = 0; i < 3; i++)
            issue(0, 0, 4'h0, 32'h44, 32'h0, 0, 32'hA5A50001, 0, acc, en);
        idle(4);
        resetn = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("mid_rst_recv_err", {30'b0, recv0, err0}, 32'h0);
        chk("mid_rst_rdata", rdata0, 32'h0);
        chk("mid_rst_gnt_en", {30'b0, gnt0, ben0}, 32'h0);
        idle(2);
        resetn = 1'b1;
        ack0 = 1'b1;
        @(negedge clk);
        chk("post_rst_gnt", {31'b0, gnt0}, 32'h1);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (recv0) bad++;
        end
        chk("post_rst_no_stale", bad, 0);

        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
